// File: rtl/trav_short_stack_if.sv
// Request/response bundle between the traversal units, the short stack and tarb.
// The short stack takes the slave modport; the traversal/tarb side takes master.
interface trav_short_stack_if #(
    parameter int NUM_IN = 2,
    parameter int RAY_W  = 9,
    parameter int P_W    = 2,
    parameter int NODE_W = 20
);
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN-1:0]         in_stall;
    logic [2*NUM_IN-1:0]       in_op;
    logic [RAY_W*NUM_IN-1:0]   in_rayID;
    logic [P_W*NUM_IN-1:0]     in_wptr;
    logic [(P_W+1)*NUM_IN-1:0] in_num;
    logic [NODE_W*NUM_IN-1:0]  in_nodeID;
    logic [32*NUM_IN-1:0]      in_t_max;

    logic                      pop_valid;
    logic                      pop_stall;
    logic [RAY_W-1:0]          pop_rayID;
    logic [NODE_W-1:0]         pop_nodeID;
    logic [31:0]               pop_t_max;
    logic [P_W-1:0]            pop_wptr;
    logic [P_W:0]              pop_num;
    logic                      pop_empty;

    modport master (
        output in_valid, in_op, in_rayID, in_wptr, in_num, in_nodeID, in_t_max, pop_stall,
        input  in_stall, pop_valid, pop_rayID, pop_nodeID, pop_t_max, pop_wptr, pop_num, pop_empty
    );

    modport slave (
        input  in_valid, in_op, in_rayID, in_wptr, in_num, in_nodeID, in_t_max, pop_stall,
        output in_stall, pop_valid, pop_rayID, pop_nodeID, pop_t_max, pop_wptr, pop_num, pop_empty
    );
endinterface

// File: rtl/trav_short_stack.sv
// Per-ray kd-tree short stack shared by NUM_IN traversal ports.
// Storage only; ray pointers arrive with each request and updated pointers leave with pops.
// Optional build macro SS_PERF_EN adds saturating push/pop/drop counters.
module trav_short_stack #(
    parameter int NUM_IN   = 2,
    parameter int NUM_RAYS = 512,
    parameter int SS_DEPTH = 4,
    parameter int NODE_W   = 20,
    localparam int RAY_W   = $clog2(NUM_RAYS),
    localparam int P_W     = $clog2(SS_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    trav_short_stack_if.slave bus
`ifdef SS_PERF_EN
    ,
    output logic [31:0]       perf_push,
    output logic [31:0]       perf_pop,
    output logic [31:0]       perf_drop
`endif
);
    localparam int A_W   = RAY_W + P_W;
    localparam int RR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int ENT_W = RAY_W + NODE_W + 32 + P_W + (P_W + 1) + 1;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_UPD  = 2'b11
    } op_e;

    // arbitration
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [NUM_IN-1:0] grant, elig;
    logic              gnt_any, pop_ok;
    op_e               g_op;
    logic [RAY_W-1:0]  g_ray;
    logic [P_W-1:0]    g_wptr, g_slot;
    logic [P_W:0]      g_num;
    logic [NODE_W-1:0] g_node;
    logic [31:0]       g_tmax;

    // registered RAM write port (also the forwarding source)
    logic              wr_valid_q, wr_valid_d, wr_node_en_q, wr_node_en_d;
    logic [A_W-1:0]    wr_addr_q, wr_addr_d;
    logic [NODE_W-1:0] wr_node_q, wr_node_d;
    logic [31:0]       wr_tmax_q, wr_tmax_d;

    // read stage
    logic              rd_en;
    logic [A_W-1:0]    rd_addr;
    logic [NODE_W+31:0] rd_raw_q;
    logic [NODE_W+31:0] mem [SS_DEPTH*NUM_RAYS];

    logic              s1_valid_q, s1_valid_d, s1_empty_q, s1_empty_d;
    logic [RAY_W-1:0]  s1_ray_q, s1_ray_d;
    logic [P_W-1:0]    s1_wptr_q, s1_wptr_d;
    logic [P_W:0]      s1_num_q, s1_num_d;
    logic              fwd_hit_q, fwd_hit_d, fwd_node_en_q, fwd_node_en_d;
    logic [NODE_W-1:0] fwd_node_q, fwd_node_d;
    logic [31:0]       fwd_tmax_q, fwd_tmax_d;
    logic [NODE_W-1:0] s1_node;
    logic [31:0]       s1_tmax;
    logic [ENT_W-1:0]  s1_ent;

    // output FIFO
    logic [ENT_W-1:0]  fifo_q [2];
    logic [ENT_W-1:0]  fifo_d [2];
    logic              fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [ENT_W-1:0]  head;
    logic              out_vld, deq, fifo_deq, enq;

    // Round-robin pick of one eligible port; POPs wait while the output path is full
    always_comb begin
        int unsigned gsel;
        int unsigned idx;
        pop_ok  = (fifo_cnt_q + {1'b0, s1_valid_q}) < 2'd2;
        grant   = '0;
        gnt_any = 1'b0;
        rr_d    = rr_q;
        gsel    = 0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            elig[i] = ~rst & bus.in_valid[i] &
                      ~((bus.in_op[2*i +: 2] == OP_POP) & ~pop_ok);
        end
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            idx = (32'(rr_q) + k) % NUM_IN;
            if (!gnt_any && elig[idx]) begin
                gnt_any     = 1'b1;
                grant[idx]  = 1'b1;
                gsel        = idx;
                rr_d        = RR_W'((idx + 1) % NUM_IN);
            end
        end
        g_op   = op_e'(bus.in_op[2*gsel +: 2]);
        g_ray  = bus.in_rayID[RAY_W*gsel +: RAY_W];
        g_wptr = bus.in_wptr[P_W*gsel +: P_W];
        g_num  = bus.in_num[(P_W+1)*gsel +: (P_W+1)];
        g_node = bus.in_nodeID[NODE_W*gsel +: NODE_W];
        g_tmax = bus.in_t_max[32*gsel +: 32];
        g_slot = g_wptr - P_W'(1);
    end

    assign bus.in_stall = bus.in_valid & ~grant;

    // Decode the granted op into a RAM write or a read-stage entry
    always_comb begin
        wr_valid_d    = 1'b0;
        wr_node_en_d  = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_node_d     = wr_node_q;
        wr_tmax_d     = wr_tmax_q;
        rd_en         = 1'b0;
        rd_addr       = {g_ray, g_slot};
        s1_valid_d    = 1'b0;
        s1_ray_d      = s1_ray_q;
        s1_wptr_d     = s1_wptr_q;
        s1_num_d      = s1_num_q;
        s1_empty_d    = s1_empty_q;
        fwd_hit_d     = 1'b0;
        fwd_node_en_d = fwd_node_en_q;
        fwd_node_d    = fwd_node_q;
        fwd_tmax_d    = fwd_tmax_q;
        if (gnt_any) begin
            case (g_op)
                OP_PUSH: begin
                    wr_valid_d   = 1'b1;
                    wr_node_en_d = 1'b1;
                    wr_addr_d    = {g_ray, g_wptr};
                    wr_node_d    = g_node;
                    wr_tmax_d    = g_tmax;
                end
                OP_UPD: begin
                    if (g_num != '0) begin
                        wr_valid_d   = 1'b1;
                        wr_node_en_d = 1'b0;
                        wr_addr_d    = {g_ray, g_slot};
                        wr_tmax_d    = g_tmax;
                    end
                end
                OP_POP: begin
                    s1_valid_d = 1'b1;
                    s1_ray_d   = g_ray;
                    if (g_num != '0) begin
                        rd_en         = 1'b1;
                        s1_wptr_d     = g_slot;
                        s1_num_d      = g_num - (P_W+1)'(1);
                        s1_empty_d    = 1'b0;
                        // The write from the previous cycle lands in the array on the same
                        // edge as this read, so the read sees old data; capture it for merging.
                        fwd_hit_d     = wr_valid_q && (wr_addr_q == rd_addr);
                        fwd_node_en_d = wr_node_en_q;
                        fwd_node_d    = wr_node_q;
                        fwd_tmax_d    = wr_tmax_q;
                    end else begin
                        s1_wptr_d  = g_wptr;
                        s1_num_d   = '0;
                        s1_empty_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stack storage: masked write, registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_valid_q) begin
            if (wr_node_en_q) mem[wr_addr_q][NODE_W+31:32] <= wr_node_q;
            mem[wr_addr_q][31:0] <= wr_tmax_q;
        end
        if (rd_en) rd_raw_q <= mem[rd_addr];
    end

    // Merge forwarded write lanes over the raw read and steer into the output FIFO
    always_comb begin
        s1_node = s1_empty_q ? '0 :
                  (fwd_hit_q && fwd_node_en_q) ? fwd_node_q : rd_raw_q[NODE_W+31:32];
        s1_tmax = s1_empty_q ? '0 : fwd_hit_q ? fwd_tmax_q : rd_raw_q[31:0];
        s1_ent  = {s1_ray_q, s1_node, s1_tmax, s1_wptr_q, s1_num_q, s1_empty_q};

        out_vld  = (fifo_cnt_q != 2'd0) | s1_valid_q;
        head     = (fifo_cnt_q != 2'd0) ? fifo_q[fifo_rp_q] : s1_ent;
        deq      = out_vld & ~bus.pop_stall;
        fifo_deq = deq & (fifo_cnt_q != 2'd0);
        enq      = s1_valid_q & ~(deq & (fifo_cnt_q == 2'd0));

        fifo_d = fifo_q;
        if (enq) fifo_d[fifo_wp_q] = s1_ent;
        fifo_wp_d  = fifo_wp_q ^ enq;
        fifo_rp_d  = fifo_rp_q ^ fifo_deq;
        fifo_cnt_d = fifo_cnt_q + {1'b0, enq} - {1'b0, fifo_deq};

        bus.pop_valid = out_vld;
        {bus.pop_rayID, bus.pop_nodeID, bus.pop_t_max, bus.pop_wptr, bus.pop_num, bus.pop_empty}
            = out_vld ? head : '0;
    end

    // Control and pipeline state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q          <= '0;
            wr_valid_q    <= 1'b0;
            wr_node_en_q  <= 1'b0;
            wr_addr_q     <= '0;
            wr_node_q     <= '0;
            wr_tmax_q     <= '0;
            s1_valid_q    <= 1'b0;
            s1_ray_q      <= '0;
            s1_wptr_q     <= '0;
            s1_num_q      <= '0;
            s1_empty_q    <= 1'b0;
            fwd_hit_q     <= 1'b0;
            fwd_node_en_q <= 1'b0;
            fwd_node_q    <= '0;
            fwd_tmax_q    <= '0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
            fifo_wp_q     <= 1'b0;
            fifo_rp_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            rr_q          <= rr_d;
            wr_valid_q    <= wr_valid_d;
            wr_node_en_q  <= wr_node_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_node_q     <= wr_node_d;
            wr_tmax_q     <= wr_tmax_d;
            s1_valid_q    <= s1_valid_d;
            s1_ray_q      <= s1_ray_d;
            s1_wptr_q     <= s1_wptr_d;
            s1_num_q      <= s1_num_d;
            s1_empty_q    <= s1_empty_d;
            fwd_hit_q     <= fwd_hit_d;
            fwd_node_en_q <= fwd_node_en_d;
            fwd_node_q    <= fwd_node_d;
            fwd_tmax_q    <= fwd_tmax_d;
            fifo_q        <= fifo_d;
            fifo_wp_q     <= fifo_wp_d;
            fifo_rp_q     <= fifo_rp_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

`ifdef SS_PERF_EN
    logic [31:0] perf_push_q, perf_push_d, perf_pop_q, perf_pop_d, perf_drop_q, perf_drop_d;

    // Saturating counters of granted ops
    always_comb begin
        perf_push_d = perf_push_q;
        perf_pop_d  = perf_pop_q;
        perf_drop_d = perf_drop_q;
        if (gnt_any && g_op == OP_PUSH && perf_push_q != '1) perf_push_d = perf_push_q + 32'd1;
        if (gnt_any && g_op == OP_POP && perf_pop_q != '1) perf_pop_d = perf_pop_q + 32'd1;
        if (gnt_any && g_op == OP_PUSH && g_num == (P_W+1)'(SS_DEPTH) && perf_drop_q != '1)
            perf_drop_d = perf_drop_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_push_q <= '0;
            perf_pop_q  <= '0;
            perf_drop_q <= '0;
        end else begin
            perf_push_q <= perf_push_d;
            perf_pop_q  <= perf_pop_d;
            perf_drop_q <= perf_drop_d;
        end
    end

    assign perf_push = perf_push_q;
    assign perf_pop  = perf_pop_q;
    assign perf_drop = perf_drop_q;
`endif
endmodule

// File: tb/tb_trav_short_stack.sv
// Scoreboard bench for trav_short_stack: a reference stack model produces the
// expected pop results at grant time; a monitor compares DUT output in order.
module tb_trav_short_stack;
    localparam int NI = 2, NR = 512, SD = 4, NW = 20, RW = 9, PW = 2;
    localparam logic [1:0] OPU = 2'b01, OPP = 2'b10, OPD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;

    trav_short_stack_if #(.NUM_IN(NI), .RAY_W(RW), .P_W(PW), .NODE_W(NW)) bus ();

    trav_short_stack #(.NUM_IN(NI), .NUM_RAYS(NR), .SS_DEPTH(SD), .NODE_W(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [8:0]  ray;
        logic [19:0] node;
        logic [31:0] tmax;
    } req_t;

    typedef struct packed {
        logic [8:0]  ray;
        logic [19:0] node;
        logic [31:0] tmax;
        logic [1:0]  wptr;
        logic [2:0]  num;
        logic        empty;
    } exp_t;

    req_t        pq [2][$];
    exp_t        sb [$];
    int          glog [$];
    logic [19:0] m_node [NR][SD];
    logic [31:0] m_tmax [NR][SD];
    int          r_wptr [NR];
    int          r_num [NR];
    int          checks = 0;
    int          failures = 0;
    int          n_pop_g = 0;
    int          n_wr_g = 0;

    // Scoreboard consumer
    always @(negedge clk) begin : mon
        exp_t a, e;
        if (!rst && bus.pop_valid && !bus.pop_stall) begin
            a = '{bus.pop_rayID, bus.pop_nodeID, bus.pop_t_max, bus.pop_wptr, bus.pop_num, bus.pop_empty};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%h required=none", a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL pop_data got ray=%0d node=%0d tmax=%h wptr=%0d num=%0d empty=%b required ray=%0d node=%0d tmax=%h wptr=%0d num=%0d empty=%b",
                             a.ray, a.node, a.tmax, a.wptr, a.num, a.empty,
                             e.ray, e.node, e.tmax, e.wptr, e.num, e.empty);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic req(input int p, input logic [1:0] op, input int ray, input int node, input logic [31:0] tmax);
        req_t r;
        r.op = op; r.ray = 9'(ray); r.node = 20'(node); r.tmax = tmax;
        pq[p].push_back(r);
    endtask

    task automatic set_ray(input int ray, input int w, input int n);
        r_wptr[ray] = w;
        r_num[ray]  = n;
    endtask

    task automatic drive_ports();
        for (int p = 0; p < NI; p++) begin
            if (pq[p].size() > 0) begin
                req_t r;
                r = pq[p][0];
                bus.in_valid[p]         = 1'b1;
                bus.in_op[2*p +: 2]     = r.op;
                bus.in_rayID[9*p +: 9]  = r.ray;
                bus.in_wptr[2*p +: 2]   = 2'(r_wptr[r.ray]);
                bus.in_num[3*p +: 3]    = 3'(r_num[r.ray]);
                bus.in_nodeID[20*p +: 20] = r.node;
                bus.in_t_max[32*p +: 32]  = r.tmax;
            end else begin
                bus.in_valid[p] = 1'b0;
            end
        end
    endtask

    task automatic apply_grant(input int p);
        req_t r;
        int w, n, s;
        r = pq[p].pop_front();
        glog.push_back(p);
        w = r_wptr[r.ray];
        n = r_num[r.ray];
        s = (w + SD - 1) % SD;
        case (r.op)
            OPU: begin
                n_wr_g++;
                m_node[r.ray][w] = r.node;
                m_tmax[r.ray][w] = r.tmax;
                r_wptr[r.ray] = (w + 1) % SD;
                if (n < SD) r_num[r.ray] = n + 1;
            end
            OPD: begin
                n_wr_g++;
                if (n > 0) m_tmax[r.ray][s] = r.tmax;
            end
            OPP: begin
                n_pop_g++;
                if (n > 0) begin
                    sb.push_back('{r.ray, m_node[r.ray][s], m_tmax[r.ray][s], 2'(s), 3'(n - 1), 1'b0});
                    r_wptr[r.ray] = s;
                    r_num[r.ray]  = n - 1;
                end else begin
                    sb.push_back('{r.ray, 20'd0, 32'd0, 2'(w), 3'd0, 1'b1});
                end
            end
            default: ;
        endcase
    endtask

    // Drives queued requests, books grants into the model; ends at posedge+1 with inputs idle
    task automatic run(input int cycles, input bit until_idle);
        int ng;
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (until_idle && pq[0].size() == 0 && pq[1].size() == 0 && sb.size() == 0) begin
                idle = 1'b1;
                break;
            end
            @(posedge clk); #1;
            drive_ports();
            @(negedge clk); #1;
            ng = 0;
            for (int p = 0; p < NI; p++) begin
                if (bus.in_valid[p] && !bus.in_stall[p]) begin
                    ng++;
                    apply_grant(p);
                end
            end
            if (bus.in_valid != '0) begin
                checks++;
                if (ng > 1) begin
                    failures++;
                    $display("FAIL one_grant got=%0d required<=1", ng);
                end
            end
        end
        @(posedge clk); #1;
        bus.in_valid = '0;
        if (until_idle) begin
            checks++;
            if (!idle) begin
                failures++;
                $display("FAIL drain_timeout got=pending(%0d,%0d,%0d) required=idle",
                         pq[0].size(), pq[1].size(), sb.size());
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.in_valid = '0;
        pq[0].delete(); pq[1].delete(); sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.pop_stall = 1'b0;
        bus.in_valid  = 2'b11;
        bus.in_op     = {OPU, OPU};
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_stall !== 2'b11) begin
            failures++;
            $display("FAIL reset_in_stall got=%b required=11", bus.in_stall);
        end
        checks++;
        if (bus.pop_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_pop_valid got=%b required=0", bus.pop_valid);
        end
        checks++;
        if ({bus.pop_rayID, bus.pop_nodeID, bus.pop_t_max, bus.pop_wptr, bus.pop_num, bus.pop_empty} !== '0) begin
            failures++;
            $display("FAIL reset_pop_data got node=%0d tmax=%h required=0", bus.pop_nodeID, bus.pop_t_max);
        end
        bus.in_valid = '0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_push_pop();
        set_ray(6, 0, 0);
        req(0, OPU, 6, 12, 32'h41200000);
        req(0, OPP, 6, 0, 32'h0);
        run(2, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.pop_valid !== 1'b1) begin
            failures++;
            $display("FAIL pop_latency got=%b required=1", bus.pop_valid);
        end
        run(10, 1'b1);
    endtask

    task automatic test_empty_pop();
        set_ray(3, 2, 0);
        req(0, OPP, 3, 0, 32'h0);
        run(10, 1'b1);
    endtask

    task automatic test_overflow();
        set_ray(4, 0, 0);
        for (int i = 1; i <= 5; i++) req(1, OPU, 4, i, 32'h3f800000 + 32'(i));
        for (int i = 0; i < 5; i++) req(1, OPP, 4, 0, 32'h0);
        run(40, 1'b1);
    endtask

    task automatic test_arbitration();
        apply_reset();
        glog.delete();
        set_ray(20, 0, 0);
        set_ray(21, 0, 0);
        for (int i = 0; i < 2; i++) begin
            req(0, OPU, 20, 100 + i, 32'h40000000 + 32'(i));
            req(0, OPP, 20, 0, 32'h0);
            req(1, OPU, 21, 200 + i, 32'h40400000 + 32'(i));
            req(1, OPP, 21, 0, 32'h0);
        end
        run(8, 1'b0);
        checks++;
        if (glog.size() != 8) begin
            failures++;
            $display("FAIL arb_grant_count got=%0d required=8", glog.size());
        end
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            checks++;
            if (glog[i] != i % 2) begin
                failures++;
                $display("FAIL arb_order[%0d] got=%0d required=%0d", i, glog[i], i % 2);
            end
        end
        run(20, 1'b1);
    endtask

    task automatic test_pop_stall();
        set_ray(30, 0, 0);
        set_ray(31, 0, 0);
        for (int i = 0; i < 4; i++) req(0, OPU, 30, 300 + i, 32'h41000000 + 32'(i));
        run(20, 1'b1);
        bus.pop_stall = 1'b1;
        n_pop_g = 0;
        n_wr_g  = 0;
        for (int i = 0; i < 4; i++) req(0, OPP, 30, 0, 32'h0);
        for (int i = 0; i < 3; i++) req(1, OPU, 31, 310 + i, 32'h41100000 + 32'(i));
        req(1, OPD, 31, 0, 32'h42000000);
        run(10, 1'b0);
        checks++;
        if (n_pop_g != 2) begin
            failures++;
            $display("FAIL stall_pop_grants got=%0d required=2", n_pop_g);
        end
        checks++;
        if (n_wr_g != 4) begin
            failures++;
            $display("FAIL stall_write_grants got=%0d required=4", n_wr_g);
        end
        @(negedge clk);
        checks++;
        if (sb.size() == 0 || bus.pop_valid !== 1'b1 || bus.pop_nodeID !== sb[0].node || bus.pop_num !== sb[0].num) begin
            failures++;
            $display("FAIL stall_hold got valid=%b node=%0d num=%0d required valid=1 node=%0d num=%0d",
                     bus.pop_valid, bus.pop_nodeID, bus.pop_num,
                     (sb.size() > 0) ? sb[0].node : 20'd0, (sb.size() > 0) ? sb[0].num : 3'd0);
        end
        bus.pop_stall = 1'b0;
        req(1, OPP, 31, 0, 32'h0);
        run(40, 1'b1);
    endtask

    task automatic test_forward_reset();
        set_ray(40, 0, 0);
        req(0, OPU, 40, 400, 32'h3f000000);
        req(0, OPP, 40, 0, 32'h0);
        req(0, OPU, 40, 401, 32'h3e000000);
        req(0, OPD, 40, 0, 32'h44444444);
        req(0, OPP, 40, 0, 32'h0);
        run(20, 1'b1);

        set_ray(41, 0, 0);
        set_ray(42, 0, 0);
        for (int i = 0; i < 4; i++) req(0, OPU, 41, 410 + i, 32'h40a00000 + 32'(i));
        run(20, 1'b1);
        for (int i = 0; i < 4; i++) req(0, OPP, 41, 0, 32'h0);
        req(1, OPU, 42, 420, 32'h1);
        req(1, OPU, 42, 421, 32'h2);
        run(3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pop_valid !== 1'b0 || bus.pop_nodeID !== '0 || bus.pop_t_max !== '0) begin
            failures++;
            $display("FAIL midreset_pop got valid=%b node=%0d tmax=%h required valid=0 node=0 tmax=0",
                     bus.pop_valid, bus.pop_nodeID, bus.pop_t_max);
        end
        pq[0].delete(); pq[1].delete(); sb.delete();
        @(posedge clk); #1 rst = 1'b0;

        glog.delete();
        set_ray(50, 0, 0);
        set_ray(51, 0, 0);
        req(0, OPU, 50, 500, 32'h5);
        req(1, OPU, 51, 510, 32'h6);
        req(0, OPP, 50, 0, 32'h0);
        req(1, OPP, 51, 0, 32'h0);
        run(20, 1'b1);
        checks++;
        if (glog.size() == 0 || glog[0] != 0) begin
            failures++;
            $display("FAIL rr_after_reset got=%0d required=0", (glog.size() > 0) ? glog[0] : -1);
        end
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_op     = '0;
        bus.in_rayID  = '0;
        bus.in_wptr   = '0;
        bus.in_num    = '0;
        bus.in_nodeID = '0;
        bus.in_t_max  = '0;
        bus.pop_stall = 1'b0;
        test_reset();
        test_push_pop();
        test_empty_pop();
        test_overflow();
        test_arbitration();
        test_pop_stall();
        test_forward_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
